// File: rtl/riscv_wb_arbiter.sv
// Two-master Wishbone (pipelined) arbiter for a RISC-V core.
// Master 0 is instruction fetch and master 1 is data. They share one bus port.
// A grant lasts for the whole bus cycle. A watchdog aborts a granted cycle
// that gets no response for too long, and reports it with a one-cycle err.
module riscv_wb_arbiter #(
  parameter int RR      = 1,    // 1: round-robin on a tie, 0: data master (m1) wins
  parameter int TIMEOUT = 255   // response-free granted cycles before abort; 0 disables
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  // master 0 (instruction fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [29:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_stall_o,
  output logic [31:0] m0_data_o,
  // master 1 (data)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [29:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_stall_o,
  output logic [31:0] m1_data_o,
  // shared bus
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_stall_i,
  input  logic [31:0] s_data_i
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t          r_state;
  logic            r_owner;        // master holding GNT or ABORT
  logic            r_abort_first;  // high only in the first ABORT cycle
  logic            last_q;         // last master to release the bus
  logic [WD_W-1:0] wd_q;           // response-free granted cycles

  state_t w_next;
  logic   w_next_owner;
  logic   w_release;
  logic   w_own_cyc;
  logic   w_oth_cyc;
  logic   w_wd_expired;
  logic   w_enter_gnt;
  logic   w_granted;

  assign w_own_cyc    = r_owner ? m1_cyc_i : m0_cyc_i;
  assign w_oth_cyc    = r_owner ? m0_cyc_i : m1_cyc_i;
  assign w_granted    = (r_state == GNT0) || (r_state == GNT1);
  // A response in the limit cycle means the cycle was not response-free,
  // so it does not trigger an abort.
  assign w_wd_expired = (TIMEOUT != 0) && (wd_q == WD_LIMIT) && !s_ack_i && !s_err_i;
  assign w_enter_gnt  = ((w_next == GNT0) || (w_next == GNT1)) && (w_next != r_state);

  // Next-state and next-owner selection
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next       = r_state;
    w_next_owner = r_owner;
    w_release    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next_owner = (RR != 0) ? ~last_q : 1'b1;
          w_next       = w_next_owner ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
          w_next_owner = 1'b0;
          w_next       = GNT0;
        end else if (m1_cyc_i) begin
          w_next_owner = 1'b1;
          w_next       = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!w_own_cyc)        w_release = 1'b1;
        else if (w_wd_expired) w_next    = ABORT;
      end
      ABORT: begin
        if (!w_own_cyc) w_release = 1'b1;
      end
    endcase
    // A release hands the bus straight to a waiting master, with no IDLE bubble.
    if (w_release) begin
      if (w_oth_cyc) begin
        w_next_owner = ~r_owner;
        w_next       = r_owner ? GNT0 : GNT1;
      end else begin
        w_next       = IDLE;
      end
    end
  end

  // State, owner, last-owner and watchdog registers
  always_ff @(posedge clk_i) begin
    // NOTE: the reset is synchronous and active-low. last_q resets to 1 so that m0 wins the first tie.
    if (!reset_ni) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_abort_first <= 1'b0;
      last_q        <= 1'b1;
      wd_q          <= '0;
    end else begin
      // NOTE: sequential state is assigned non-blocking so all registers update together.
      r_state       <= w_next;
      r_owner       <= w_next_owner;
      r_abort_first <= (w_next == ABORT) && (r_state != ABORT);
      if (w_release) last_q <= r_owner;
      if (w_enter_gnt || s_ack_i || s_err_i || !w_granted) wd_q <= '0;
      else if (wd_q != '1)                                 wd_q <= wd_q + 1'b1;
    end
  end

  // Bus routing and master responses from the current state
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_data_o   = '0;
    s_sel_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    unique case (r_state)
      IDLE: ;
      GNT0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_data_o   = m0_data_i;
        s_sel_o    = m0_sel_i;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
        m0_stall_o = s_stall_i;
      end
      GNT1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_addr_o   = m1_addr_i;
        s_data_o   = m1_data_i;
        s_sel_o    = m1_sel_i;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
        m1_stall_o = s_stall_i;
      end
      ABORT: begin
        if (r_owner) m1_err_o = r_abort_first;
        else         m0_err_o = r_abort_first;
      end
    endcase
  end

  // Read data goes to both masters; each one qualifies it with its own ack.
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter. Two instances share every input:
// u[0] uses round-robin and u[1] uses fixed priority, both with TIMEOUT=4.
// A behavioural model of each instance predicts its outputs in every cycle.
// Directed scenarios come first, then a randomized run.
module tb_riscv_wb_arbiter;

  localparam int          TMO = 4;
  localparam logic [29:0] A0  = 30'h0000010;
  localparam logic [29:0] A1  = 30'h0000200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_err, s_stall;
  logic [31:0] s_rdata;

  logic        m0_ack[2], m0_err[2], m0_stall[2], m1_ack[2], m1_err[2], m1_stall[2];
  logic [31:0] m0_dout[2], m1_dout[2], s_dout[2];
  logic        s_cyc[2], s_stb[2], s_we[2];
  logic [29:0] s_addr[2];
  logic [3:0]  s_sel[2];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_wb_arbiter #(.RR(g == 0 ? 1 : 0), .TIMEOUT(TMO)) u_dut (
      .clk_i(clk), .reset_ni(reset_ni),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack[g]), .m0_err_o(m0_err[g]),
      .m0_stall_o(m0_stall[g]), .m0_data_o(m0_dout[g]),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack[g]), .m1_err_o(m1_err[g]),
      .m1_stall_o(m1_stall[g]), .m1_data_o(m1_dout[g]),
      .s_cyc_o(s_cyc[g]), .s_stb_o(s_stb[g]), .s_we_o(s_we[g]), .s_addr_o(s_addr[g]),
      .s_data_o(s_dout[g]), .s_sel_o(s_sel[g]),
      .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_data_i(s_rdata)
    );
  end

  // Model state: who owns the bus (-1 if nobody), abort status,
  // the number of response-free granted cycles so far, and the last releaser.
  typedef struct {
    int owner;
    bit abort;
    bit abort_first;
    int silent;
    int last;
  } mdl_t;

  mdl_t mdl[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic mdl_t next_model(input mdl_t m, input bit rr);
    bit c[2];
    c[0] = m0_cyc;
    c[1] = m1_cyc;
    if (!reset_ni) begin
      m = '{owner: -1, abort: 1'b0, abort_first: 1'b0, silent: 0, last: 1};
    end else if (m.owner < 0) begin
      if (c[0] && c[1]) m.owner = rr ? 1 - m.last : 1;
      else if (c[0])    m.owner = 0;
      else if (c[1])    m.owner = 1;
      m.silent = 0;
    end else if (!c[m.owner]) begin
      m.last        = m.owner;
      m.abort       = 1'b0;
      m.abort_first = 1'b0;
      m.silent      = 0;
      m.owner       = c[1 - m.owner] ? 1 - m.owner : -1;
    end else if (m.abort) begin
      m.abort_first = 1'b0;
    end else if (s_ack || s_err) begin
      m.silent = 0;
    end else if (m.silent == TMO) begin
      m.abort       = 1'b1;
      m.abort_first = 1'b1;
    end else begin
      m.silent++;
    end
    return m;
  endfunction

  task automatic check_dut(input int k);
    logic [68:0] eb;
    logic [2:0]  e0, e1;
    eb = '0;
    e0 = 3'b001;
    e1 = 3'b001;
    if (mdl[k].owner >= 0 && !mdl[k].abort) begin
      if (mdl[k].owner == 0) begin
        eb = {m0_cyc, m0_stb, m0_we, m0_addr, m0_wdata, m0_sel};
        e0 = {s_ack, s_err, s_stall};
      end else begin
        eb = {m1_cyc, m1_stb, m1_we, m1_addr, m1_wdata, m1_sel};
        e1 = {s_ack, s_err, s_stall};
      end
    end else if (mdl[k].abort) begin
      if (mdl[k].owner == 0) e0[1] = mdl[k].abort_first;
      else                   e1[1] = mdl[k].abort_first;
    end
    chk($sformatf("bus%0d", k), {s_cyc[k], s_stb[k], s_we[k], s_addr[k], s_dout[k], s_sel[k]}, eb);
    chk($sformatf("m0_resp%0d", k), {m0_ack[k], m0_err[k], m0_stall[k]}, e0);
    chk($sformatf("m1_resp%0d", k), {m1_ack[k], m1_err[k], m1_stall[k]}, e1);
    chk($sformatf("m0_rdata%0d", k), m0_dout[k], s_rdata);
    chk($sformatf("m1_rdata%0d", k), m1_dout[k], s_rdata);
  endtask

  task automatic sample();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic tick();
    mdl_t n0, n1;
    n0 = next_model(mdl[0], 1'b1);
    n1 = next_model(mdl[1], 1'b0);
    @(posedge clk);
    mdl[0] = n0;
    mdl[1] = n1;
    cyc_n++;
    #1;
  endtask

  task automatic drive_m0(input logic c, input logic s, input logic w,
                          input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_addr = a; m0_wdata = d; m0_sel = sl;
  endtask

  task automatic drive_m1(input logic c, input logic s, input logic w,
                          input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_addr = a; m1_wdata = d; m1_sel = sl;
  endtask

  initial begin
    int  n_gnt;
    bit  seen_err;
    bit  a0, a1, prev_m1_cyc;

    reset_ni = 1'b0;
    drive_m0(0, 0, 0, '0, '0, '0);
    drive_m1(0, 0, 0, '0, '0, '0);
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdata = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      mdl[k] = '{owner: -1, abort: 1'b0, abort_first: 1'b0, silent: 0, last: 1};

    // Reset values
    sample();
    chk("rst_scyc", s_cyc[0], 1'b0);
    chk("rst_m0_stall", m0_stall[0], 1'b1);
    tick();
    reset_ni = 1'b1;

    // Single m0 read with a one-cycle grant latency
    drive_m0(1, 1, 0, A0, 32'h0, 4'hf);
    sample(); chk("r029_lat_idle", s_cyc[0], 1'b0); tick();
    sample(); chk("r029_granted", s_cyc[0], 1'b1); chk("r029_addr", s_addr[0], A0);
    chk("r029_m1_stall", m1_stall[0], 1'b1); tick();
    m0_stb = 1'b0;
    sample(); tick();
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    sample(); chk("r029_ack", m0_ack[0], 1'b1); chk("r029_data", m0_dout[0], 32'hDEADBEEF);
    chk("r029_m1_noack", m1_ack[0], 1'b0); tick();
    s_ack = 1'b0; m0_cyc = 1'b0;
    sample(); chk("r029_release", s_cyc[0], 1'b0); tick();

    // Reset again so the tie rule starts from its reset value
    reset_ni = 1'b0; sample(); tick(); reset_ni = 1'b1;

    // Tie after reset, then a hand-over with no IDLE bubble
    drive_m0(1, 1, 0, A0, 32'h0, 4'hf);
    drive_m1(1, 1, 1, A1, 32'h5555, 4'h3);
    sample(); tick();
    sample(); chk("r030_first_m0", s_addr[0], A0); chk("r031_tie_m1", s_addr[1], A1); tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    sample(); tick();
    sample(); chk("r030_handover", {s_cyc[0], s_addr[0]}, {1'b1, A1}); tick();
    m1_cyc = 1'b0;
    sample(); tick();
    for (int i = 0; i < 3; i++) begin
      logic [29:0] exp_a;
      exp_a = (i % 2 == 0) ? A0 : A1;
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      sample(); tick();
      sample();
      chk($sformatf("r030_tie%0d", i), s_addr[0], exp_a);
      chk($sformatf("r031_fixed_tie%0d", i), s_addr[1], A1);
      tick();
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      sample(); tick();
    end

    // Fixed priority with one-cycle transactions: each master drops cyc
    // for one cycle after u[1] acks it.
    s_ack = 1'b1; m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    prev_m1_cyc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (s_cyc[1] && s_addr[1] == A0) chk("r031_m0_only_when_m1_low", prev_m1_cyc, 1'b0);
      a0 = m0_ack[1];
      a1 = m1_ack[1];
      prev_m1_cyc = m1_cyc;
      tick();
      m0_cyc = !a0;
      m1_cyc = !a1;
    end
    s_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
    sample(); tick();
    sample(); tick();

    // m1 write with the slave stalling for three cycles
    drive_m0(0, 0, 0, A0, 32'h0, 4'h0);
    drive_m1(1, 1, 1, A1, 32'h12345678, 4'b0011);
    s_stall = 1'b1;
    sample(); tick();
    for (int j = 0; j < 3; j++) begin
      sample();
      chk("r032_stall_mirror", m1_stall[0], 1'b1);
      chk("r032_bus_stable", {s_we[0], s_sel[0], s_dout[0]}, {1'b1, 4'b0011, 32'h12345678});
      chk("r032_m0_noack", m0_ack[0], 1'b0);
      tick();
    end
    s_stall = 1'b0; s_ack = 1'b1;
    sample();
    chk("r032_ack", {m1_ack[0], m1_stall[0], m0_ack[0]}, 3'b100);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    sample(); tick();

    // Watchdog: the slave never answers m0
    drive_m0(1, 1, 0, A0, 32'h0, 4'hf);
    sample(); tick();
    n_gnt = 0; seen_err = 1'b0;
    for (int j = 0; j < 20 && !seen_err; j++) begin
      sample();
      if (m0_err[0]) seen_err = 1'b1;
      else if (s_cyc[0]) n_gnt++;
      tick();
    end
    chk("r033_err_seen", seen_err, 1'b1);
    chk("r033_granted_cycles", n_gnt, TMO + 1);
    sample();
    chk("r033_err_once", {m0_err[0], s_cyc[0], m0_stall[0]}, 3'b001);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    sample(); tick();
    sample(); chk("r033_idle", s_cyc[0], 1'b0); tick();

    // Reset in the middle of an m1 transfer
    drive_m1(1, 1, 0, A1, 32'h0, 4'hf);
    sample(); tick();
    sample(); chk("r034_gnt1", s_cyc[0], 1'b1); tick();
    reset_ni = 1'b0; m0_cyc = 1'b1;
    sample(); tick();
    reset_ni = 1'b1;
    sample(); chk("r034_scyc", s_cyc[0], 1'b0); chk("r034_noerr", m1_err[0], 1'b0); tick();
    sample(); chk("r034_tie_m0", {s_cyc[0], s_addr[0]}, {1'b1, A0}); tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    sample(); tick();

    // Randomized traffic checked against the model
    for (int i = 0; i < 1500; i++) begin
      m0_cyc   = m0_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m1_cyc   = m1_cyc ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m0_stb   = 1'($urandom_range(0, 1));
      m1_stb   = 1'($urandom_range(0, 1));
      m0_we    = 1'($urandom_range(0, 1));
      m1_we    = 1'($urandom_range(0, 1));
      m0_addr  = 30'($urandom);
      m1_addr  = 30'($urandom);
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      m0_sel   = 4'($urandom_range(0, 15));
      m1_sel   = 4'($urandom_range(0, 15));
      s_ack    = ($urandom_range(0, 2) == 0);
      s_err    = ($urandom_range(0, 15) == 0);
      s_stall  = 1'($urandom_range(0, 1));
      s_rdata  = $urandom;
      reset_ni = ($urandom_range(0, 199) != 0);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
